// File: rtl/mgmt_stream_demux_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mgmt_stream_demux_pkg
// Desc     : Shared constants and FSM encoding for the management stream demux.
// Revision : 1.0 - initial release
//==============================================================================
package mgmt_stream_demux_pkg;

    localparam int C_DST_PORT_POS = 24;
    localparam int C_DST_WIDTH    = 8;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_FWD  = 2'd1;
    localparam logic [1:0] C_ST_DROP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mgmt_stream_demux_fifo.sv
`default_nettype none
//==============================================================================
// Module   : fallthrough_small_fifo
// Desc     : Small first-word-fall-through FIFO; head word is valid whenever !empty.
// Revision : 1.0 - initial release
//==============================================================================
module fallthrough_small_fifo
    import mgmt_stream_demux_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);

    localparam int                      C_DEPTH_INT = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH     = C_DEPTH_INT[MAX_DEPTH_BITS:0];

    logic [WIDTH-1:0]          r_mem [C_DEPTH_INT];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_wr;
    logic                      w_rd;

    assign w_wr        = wr_en && (r_count != C_DEPTH);
    assign w_rd        = rd_en && (r_count != '0);
    assign dout        = r_mem[r_rd_ptr];
    assign empty       = (r_count == '0);
    // One slot of slack so the upstream ready can stay a registered-state function.
    assign nearly_full = (r_count >= (C_DEPTH - (MAX_DEPTH_BITS+1)'(1)));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (MAX_DEPTH_BITS+1)'(1);
                2'b01:   r_count <= r_count - (MAX_DEPTH_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mgmt_stream_demux.sv
`default_nettype none
//==============================================================================
// Module   : mgmt_stream_demux
// Desc     : Routes each packet of one AXI4-Stream to port 0, port 1, both or none.
// Revision : 1.0 - initial release
//==============================================================================
module mgmt_stream_demux
    import mgmt_stream_demux_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = C_DST_PORT_POS,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                                axi_aclk,
    input  logic                                axi_areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_0,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_0,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_0,
    output logic                                m_axis_tvalid_0,
    input  logic                                m_axis_tready_0,
    output logic                                m_axis_tlast_0,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_1,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_1,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_1,
    output logic                                m_axis_tvalid_1,
    input  logic                                m_axis_tready_1,
    output logic                                m_axis_tlast_1,

    output logic [31:0]                         pkt_cnt_0,
    output logic [31:0]                         pkt_cnt_1,
    output logic [31:0]                         drop_cnt
);

    localparam int C_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int C_FIFO_W = 1 + C_M_AXIS_TUSER_WIDTH + C_STRB_W + C_M_AXIS_DATA_WIDTH;

    logic [C_FIFO_W-1:0]             w_fifo_din;
    logic [C_FIFO_W-1:0]             w_fifo_dout;
    logic                            w_fifo_empty;
    logic                            w_fifo_nearly_full;
    logic                            w_fifo_wr;

    logic                            w_head_valid;
    logic                            w_head_last;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] w_head_user;
    logic [C_STRB_W-1:0]             w_head_strb;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  w_head_data;

    logic [1:0]                      r_state;
    logic [1:0]                      r_sel;
    logic [1:0]                      r_sent;
    logic [31:0]                     r_pkt_cnt_0;
    logic [31:0]                     r_pkt_cnt_1;
    logic [31:0]                     r_drop_cnt;

    logic                            w_idle;
    logic [1:0]                      w_sel;
    logic                            w_fwd;
    logic                            w_drop;
    logic [1:0]                      w_tvalid;
    logic [1:0]                      w_xfer;
    logic [1:0]                      w_done;
    logic                            w_pop;

    assign s_axis_tready = !w_fifo_nearly_full && !axi_areset;
    assign w_fifo_wr     = s_axis_tvalid && s_axis_tready;
    assign w_fifo_din    = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    fallthrough_small_fifo #(
        .WIDTH          (C_FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (axi_aclk),
        .rst         (axi_areset),
        .din         (w_fifo_din),
        .wr_en       (w_fifo_wr),
        .rd_en       (w_pop),
        .dout        (w_fifo_dout),
        .empty       (w_fifo_empty),
        .nearly_full (w_fifo_nearly_full)
    );

    assign w_head_valid = !w_fifo_empty;
    assign {w_head_last, w_head_user, w_head_strb, w_head_data} = w_fifo_dout;

    // A first beat is decided in the same cycle it reaches the head, so sel comes
    // straight from the head while idle and from the latched copy afterwards.
    always_comb begin
        w_idle   = (r_state == C_ST_IDLE);
        w_sel    = w_idle ? w_head_user[DST_PORT_POS +: 2] : r_sel;
        w_fwd    = w_head_valid && ((r_state == C_ST_FWD)  || (w_idle && (w_sel != 2'b00)));
        w_drop   = w_head_valid && ((r_state == C_ST_DROP) || (w_idle && (w_sel == 2'b00)));
        w_tvalid = {2{w_fwd}} & w_sel & ~r_sent;
        w_xfer   = w_tvalid & {m_axis_tready_1, m_axis_tready_0};
        w_done   = ~w_sel | r_sent | w_xfer;
        w_pop    = (w_fwd && (&w_done)) || w_drop;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state     <= C_ST_IDLE;
            r_sel       <= 2'b00;
            r_sent      <= 2'b00;
            r_pkt_cnt_0 <= 32'd0;
            r_pkt_cnt_1 <= 32'd0;
            r_drop_cnt  <= 32'd0;
        end else begin
            if (w_idle && w_head_valid) begin
                r_sel <= w_sel;
            end

            if (w_pop) begin
                r_sent <= 2'b00;
            end else begin
                r_sent <= r_sent | w_xfer;
            end

            if (w_pop && w_head_last) begin
                r_state <= C_ST_IDLE;
            end else if (w_fwd) begin
                r_state <= C_ST_FWD;
            end else if (w_drop) begin
                r_state <= C_ST_DROP;
            end

            if (w_pop && w_head_last && w_fwd && w_sel[0]) begin
                r_pkt_cnt_0 <= r_pkt_cnt_0 + 32'd1;
            end
            if (w_pop && w_head_last && w_fwd && w_sel[1]) begin
                r_pkt_cnt_1 <= r_pkt_cnt_1 + 32'd1;
            end
            if (w_pop && w_head_last && w_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    assign m_axis_tdata_0  = w_head_data;
    assign m_axis_tstrb_0  = w_head_strb;
    assign m_axis_tuser_0  = w_head_user;
    assign m_axis_tlast_0  = w_head_last;
    assign m_axis_tvalid_0 = w_tvalid[0];

    assign m_axis_tdata_1  = w_head_data;
    assign m_axis_tstrb_1  = w_head_strb;
    assign m_axis_tuser_1  = w_head_user;
    assign m_axis_tlast_1  = w_head_last;
    assign m_axis_tvalid_1 = w_tvalid[1];

    assign pkt_cnt_0 = r_pkt_cnt_0;
    assign pkt_cnt_1 = r_pkt_cnt_1;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mgmt_stream_demux.sv
`default_nettype none
//==============================================================================
// Module   : tb_mgmt_stream_demux
// Desc     : Randomized self-checking bench with a per-port expected-beat queue model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mgmt_stream_demux;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int BW = 1 + UW + SW + DW;

    logic          axi_aclk;
    logic          axi_areset;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata_0,  m_axis_tdata_1;
    logic [SW-1:0] m_axis_tstrb_0,  m_axis_tstrb_1;
    logic [UW-1:0] m_axis_tuser_0,  m_axis_tuser_1;
    logic          m_axis_tvalid_0, m_axis_tvalid_1;
    logic          m_axis_tready_0, m_axis_tready_1;
    logic          m_axis_tlast_0,  m_axis_tlast_1;
    logic [31:0]   pkt_cnt_0, pkt_cnt_1, drop_cnt;

    mgmt_stream_demux dut (
        .axi_aclk        (axi_aclk),
        .axi_areset      (axi_areset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata_0  (m_axis_tdata_0),
        .m_axis_tstrb_0  (m_axis_tstrb_0),
        .m_axis_tuser_0  (m_axis_tuser_0),
        .m_axis_tvalid_0 (m_axis_tvalid_0),
        .m_axis_tready_0 (m_axis_tready_0),
        .m_axis_tlast_0  (m_axis_tlast_0),
        .m_axis_tdata_1  (m_axis_tdata_1),
        .m_axis_tstrb_1  (m_axis_tstrb_1),
        .m_axis_tuser_1  (m_axis_tuser_1),
        .m_axis_tvalid_1 (m_axis_tvalid_1),
        .m_axis_tready_1 (m_axis_tready_1),
        .m_axis_tlast_1  (m_axis_tlast_1),
        .pkt_cnt_0       (pkt_cnt_0),
        .pkt_cnt_1       (pkt_cnt_1),
        .drop_cnt        (drop_cnt)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int          n_total;
    int          n_bad;
    int          n_acc;
    bit          rnd_mode;
    logic [31:0] exp_cnt_0, exp_cnt_1, exp_drop;
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    // Offers one packet; the model records each beat on the ports its first-beat sel names.
    task automatic send_pkt(input logic [1:0] sel, input int nbeats, input bit with_last);
        logic [7:0]    dst;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic          l;
        int            waitc;
        dst = {6'($urandom), sel};
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
            u = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) u[24 +: 8] = dst;
            s = $urandom;
            l = with_last && (b == nbeats - 1);
            s_axis_tdata  = d;
            s_axis_tuser  = u;
            s_axis_tstrb  = s;
            s_axis_tlast  = l;
            s_axis_tvalid = 1'b1;
            waitc = 0;
            @(negedge axi_aclk);
            while (!s_axis_tready && waitc < 300) begin
                @(negedge axi_aclk);
                waitc++;
            end
            if (!s_axis_tready) begin
                chk("send_timeout", 512'(1'b0), 512'(1'b1));
                break;
            end
            n_acc++;
            if (sel[0]) q0.push_back({l, u, s, d});
            if (sel[1]) q1.push_back({l, u, s, d});
            if (l) begin
                if (sel[0]) exp_cnt_0 = exp_cnt_0 + 32'd1;
                if (sel[1]) exp_cnt_1 = exp_cnt_1 + 32'd1;
                if (sel == 2'b00) exp_drop = exp_drop + 32'd1;
            end
            @(posedge axi_aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic settle();
        int c;
        rnd_mode = 1'b0;
        m_axis_tready_0 = 1'b1;
        m_axis_tready_1 = 1'b1;
        c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < 500) begin
            tick(1);
            c++;
        end
        if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", 512'(1'b0), 512'(1'b1));
        tick(8);
        chk("pkt_cnt_0", 512'(pkt_cnt_0), 512'(exp_cnt_0));
        chk("pkt_cnt_1", 512'(pkt_cnt_1), 512'(exp_cnt_1));
        chk("drop_cnt",  512'(drop_cnt),  512'(exp_drop));
    endtask

    task automatic chk_reset_state();
        chk("rst_s_tready", 512'(s_axis_tready),   512'(1'b0));
        chk("rst_tvalid_0", 512'(m_axis_tvalid_0), 512'(1'b0));
        chk("rst_tvalid_1", 512'(m_axis_tvalid_1), 512'(1'b0));
        chk("rst_pkt_cnt_0", 512'(pkt_cnt_0), 512'(1'b0));
        chk("rst_pkt_cnt_1", 512'(pkt_cnt_1), 512'(1'b0));
        chk("rst_drop_cnt",  512'(drop_cnt),  512'(1'b0));
    endtask

    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            if (rnd_mode) begin
                m_axis_tready_0 = ($urandom_range(0, 3) != 0);
                m_axis_tready_1 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Port monitors: each handshake must match the next expected beat, and a
    // stalled tvalid must hold with unchanged data.
    logic          pv0, pr0, pv1, pr1;
    logic [BW-1:0] pb0, pb1;
    logic [BW-1:0] w_beat0, w_beat1;
    assign w_beat0 = {m_axis_tlast_0, m_axis_tuser_0, m_axis_tstrb_0, m_axis_tdata_0};
    assign w_beat1 = {m_axis_tlast_1, m_axis_tuser_1, m_axis_tstrb_1, m_axis_tdata_1};

    always @(negedge axi_aclk) begin
        if (axi_areset) begin
            pv0 <= 1'b0; pr0 <= 1'b0; pv1 <= 1'b0; pr1 <= 1'b0;
        end else begin
            if (pv0 && !pr0) chk("p0_hold", 512'({m_axis_tvalid_0, w_beat0}), 512'({1'b1, pb0}));
            if (pv1 && !pr1) chk("p1_hold", 512'({m_axis_tvalid_1, w_beat1}), 512'({1'b1, pb1}));
            if (m_axis_tvalid_0 && m_axis_tready_0) begin
                if (q0.size() == 0) chk("p0_extra_beat", 512'(w_beat0), 512'(1'b0));
                else                chk("p0_beat", 512'(w_beat0), 512'(q0.pop_front()));
            end
            if (m_axis_tvalid_1 && m_axis_tready_1) begin
                if (q1.size() == 0) chk("p1_extra_beat", 512'(w_beat1), 512'(1'b0));
                else                chk("p1_beat", 512'(w_beat1), 512'(q1.pop_front()));
            end
            pv0 <= m_axis_tvalid_0; pr0 <= m_axis_tready_0; pb0 <= w_beat0;
            pv1 <= m_axis_tvalid_1; pr1 <= m_axis_tready_1; pb1 <= w_beat1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_total = 0; n_bad = 0; n_acc = 0; rnd_mode = 1'b0;
        exp_cnt_0 = '0; exp_cnt_1 = '0; exp_drop = '0;
        axi_areset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tstrb = '0;
        m_axis_tready_0 = 1'b0; m_axis_tready_1 = 1'b0;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk_reset_state();
        @(posedge axi_aclk);
        #1 axi_areset = 1'b0;
        tick(2);

        // unicast to port 0
        m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1;
        send_pkt(2'b01, 3, 1'b1);
        settle();

        // broadcast with port 1 stalled
        m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b0;
        fork send_pkt(2'b11, 2, 1'b1); join_none
        tick(4);
        chk("skew_tvalid_0", 512'(m_axis_tvalid_0), 512'(1'b0));
        chk("skew_tvalid_1", 512'(m_axis_tvalid_1), 512'(1'b1));
        tick(1);
        m_axis_tready_1 = 1'b1;
        wait fork;
        settle();

        // drop followed immediately by port-1 unicast
        send_pkt(2'b00, 4, 1'b1);
        send_pkt(2'b10, 3, 1'b1);
        settle();

        // backpressure: nothing drains, upstream ready must fall at nearly-full
        m_axis_tready_0 = 1'b0; m_axis_tready_1 = 1'b0;
        n_acc = 0;
        fork send_pkt(2'b11, 8, 1'b1); join_none
        tick(10);
        chk("bp_s_tready", 512'(s_axis_tready), 512'(1'b0));
        chk("bp_accepted", 512'(n_acc), 512'(3));
        m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1;
        wait fork;
        settle();

        // randomized traffic with random downstream readies, including single-beat packets
        rnd_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_pkt(2'($urandom), $urandom_range(1, 5), 1'b1);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
        settle();

        // reset in the middle of a packet
        m_axis_tready_0 = 1'b0; m_axis_tready_1 = 1'b0;
        send_pkt(2'b01, 2, 1'b0);
        axi_areset = 1'b1;
        @(negedge axi_aclk);
        chk_reset_state();
        q0.delete(); q1.delete();
        exp_cnt_0 = '0; exp_cnt_1 = '0; exp_drop = '0;
        tick(2);
        axi_areset = 1'b0;
        m_axis_tready_0 = 1'b1; m_axis_tready_1 = 1'b1;
        tick(1);
        send_pkt(2'b10, 1, 1'b1);
        settle();

        // counter wrap on port 0
        @(negedge axi_aclk);
        force dut.r_pkt_cnt_0 = 32'hFFFF_FFFF;
        @(posedge axi_aclk);
        #1 release dut.r_pkt_cnt_0;
        exp_cnt_0 = 32'hFFFF_FFFF;
        tick(1);
        chk("wrap_preload", 512'(pkt_cnt_0), 512'(32'hFFFF_FFFF));
        send_pkt(2'b01, 2, 1'b1);
        settle();
        chk("wrap_zero", 512'(pkt_cnt_0), 512'(32'd0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
